// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and SPI mode constants.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      TRAIL,
      DONE
   } spi_state_e;

   // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   // SCLK level for a given phase (active = inside the high half-period).
   function automatic logic spi_sclk_level(input logic active);
      return active ^ SPI_CPOL;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// WIDTH-bit left-shifting register with parallel load, serial in and MSB serial out.
module spi_shift_reg
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             ser_i,
   output logic             ser_o,
   output logic [WIDTH-1:0] par_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next value: load wins over shift; shift moves towards the MSB.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {data_q[WIDTH-2:0], ser_i};
      end
   end

   // Register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign ser_o = data_q[WIDTH-1];
   assign par_o = data_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one WIDTH-bit full-duplex transfer per accepted start.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CLKDIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi,
   input  logic             miso
);

   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned DW = $clog2(CLKDIV) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
   localparam logic SAMPLE_ON_LEAD = (SPI_CPHA == 1'b0);

   spi_state_e       state_q, state_d;
   logic [DW-1:0]    div_q, div_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;

   logic             tx_load;
   logic             tx_shift;
   logic             rx_shift;
   logic             tx_msb;
   logic [WIDTH-1:0] tx_par;
   logic             rx_ser;
   logic [WIDTH-1:0] rx_word;
   logic             expire;
   logic             unused_taps;

   assign expire      = (div_q == DIV_LAST);
   assign unused_taps = ^{tx_par, rx_ser};
   assign rx_data     = rx_data_q;

   spi_shift_reg #(.WIDTH(WIDTH)) u_tx_sr (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (tx_load),
      .shift_i     (tx_shift),
      .load_data_i (tx_data),
      .ser_i       (1'b0),
      .ser_o       (tx_msb),
      .par_o       (tx_par)
   );

   spi_shift_reg #(.WIDTH(WIDTH)) u_rx_sr (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (1'b0),
      .shift_i     (rx_shift),
      .load_data_i ('0),
      .ser_i       (miso),
      .ser_o       (rx_ser),
      .par_o       (rx_word)
   );

   // State, divider, bit counter and output word registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         rx_data_q <= rx_data_d;
      end
   end

   // Next-state, counter updates, shift strobes and pin levels per state.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q + DW'(1);
      bit_d     = bit_q;
      rx_data_d = rx_data_q;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
      rx_shift  = 1'b0;
      cs_n      = 1'b0;
      sclk      = spi_sclk_level(1'b0);
      mosi      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cs_n  = 1'b1;
            busy  = 1'b0;
            div_d = '0;
            bit_d = '0;
            if (start) begin
               tx_load = 1'b1;
               state_d = LEAD;
            end
         end
         LEAD: begin
            mosi = tx_msb;
            if (expire) begin
               div_d    = '0;
               rx_shift = SAMPLE_ON_LEAD;
               state_d  = HIGH;
            end
         end
         HIGH: begin
            sclk = spi_sclk_level(1'b1);
            mosi = tx_msb;
            if (expire) begin
               div_d = '0;
               if (bit_q == LAST_BIT) begin
                  state_d = TRAIL;
               end else begin
                  bit_d    = bit_q + BW'(1);
                  tx_shift = 1'b1;
                  state_d  = LOW;
               end
            end
         end
         LOW: begin
            mosi = tx_msb;
            if (expire) begin
               div_d    = '0;
               rx_shift = SAMPLE_ON_LEAD;
               state_d  = HIGH;
            end
         end
         TRAIL: begin
            mosi = tx_msb;
            if (expire) begin
               div_d     = '0;
               rx_data_d = rx_word;
               state_d   = DONE;
            end
         end
         DONE: begin
            cs_n    = 1'b1;
            done    = 1'b1;
            div_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cs_n    = 1'b1;
            div_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl (8-bit/div-4 and 4-bit/div-1 instances).
module tb_spi_master_ctrl;

   typedef struct {
      int         cs_low;
      int         rises;
      int         ones;
      int         gap;
      logic [7:0] mosi_w;
      logic [7:0] exp_rx;
      logic [7:0] rx;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start_a = 1'b0;
   logic [7:0] tx_a = '0;
   logic [7:0] rx_a;
   logic       busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;

   logic       start_b = 1'b0;
   logic [3:0] tx_b = '0;
   logic [3:0] rx_b;
   logic       busy_b, done_b, sclk_b, cs_b, mosi_b;

   int         checks = 0;
   int         errors = 0;

   // miso source for instance A: 0 = loopback, 1 = random, 2 = tied high
   int         miso_mode = 0;
   logic       miso_rnd = 1'b0;
   logic       miso_prev = 1'b0;
   logic       sclk_prev = 1'b0;

   int         acc_cs = 0, acc_rises = 0, acc_ones = 0, acc_gap = 0, hi_run = 0;
   logic [7:0] acc_mosi = '0, acc_exp = '0;
   int         busy_bad = 0;
   rec_t       recs[$];

   always #5 clk = ~clk;

   assign miso_a = (miso_mode == 0) ? mosi_a : (miso_mode == 1) ? miso_rnd : 1'b1;

   spi_master_ctrl #(.WIDTH(8), .CLKDIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .rx_data(rx_a),
      .busy(busy_a), .done(done_a), .sclk(sclk_a), .cs_n(cs_a), .mosi(mosi_a), .miso(miso_a)
   );

   spi_master_ctrl #(.WIDTH(4), .CLKDIV(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .rx_data(rx_b),
      .busy(busy_b), .done(done_b), .sclk(sclk_b), .cs_n(cs_b), .mosi(mosi_b), .miso(mosi_b)
   );

   // Protocol observer for instance A: what a slave would see on the wire.
   always @(negedge clk) begin
      logic nb;
      rec_t t;
      if (cs_a) begin
         if (done_a) begin
            t.cs_low = acc_cs;   t.rises = acc_rises; t.ones = acc_ones;
            t.gap    = acc_gap;  t.mosi_w = acc_mosi; t.exp_rx = acc_exp;
            t.rx     = rx_a;
            recs.push_back(t);
         end
         acc_cs = 0; acc_rises = 0; acc_ones = 0; acc_mosi = '0; acc_exp = '0;
         hi_run++;
      end else begin
         if (hi_run != 0) begin
            acc_gap = hi_run;
            hi_run  = 0;
         end
         acc_cs++;
         if (mosi_a) acc_ones++;
         if (sclk_a && !sclk_prev) begin
            acc_rises++;
            acc_mosi = {acc_mosi[6:0], mosi_a};
            acc_exp  = {acc_exp[6:0], miso_prev};
         end
      end
      if (busy_a !== (!cs_a || done_a)) busy_bad++;
      sclk_prev = sclk_a;
      nb        = 1'($urandom_range(0, 1));
      miso_rnd  = nb;
      miso_prev = (miso_mode == 0) ? mosi_a : (miso_mode == 1) ? nb : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input logic [7:0] d);
      @(negedge clk);
      start_a = 1'b1;
      tx_a    = d;
      @(negedge clk);
      start_a = 1'b0;
      tx_a    = ~d;
   endtask

   task automatic wait_rec(input string tag, output rec_t r);
      for (int i = 0; i < 400; i++) begin
         if (recs.size() > 0) break;
         @(negedge clk);
      end
      if (recs.size() > 0) begin
         r = recs.pop_front();
      end else begin
         chk({tag, ".timeout"}, 32'd0, 32'd1);
         r = '{default: 0};
      end
   endtask

   task automatic wait_rises(input int n);
      for (int i = 0; i < 200; i++) begin
         if (acc_rises >= n) break;
         @(negedge clk);
      end
   endtask

   task automatic check_rec(input string tag, input rec_t r, input logic [7:0] tx,
                            input logic [7:0] rx_model, input bit model_known);
      chk({tag, ".cs_low"}, r.cs_low, 68);
      chk({tag, ".rises"}, r.rises, 8);
      chk({tag, ".mosi"}, r.mosi_w, tx);
      chk({tag, ".rx_wire"}, r.rx, r.exp_rx);
      if (model_known) chk({tag, ".rx"}, r.rx, rx_model);
   endtask

   initial begin
      rec_t r, r2;
      logic [7:0] d;
      int n, cs_lo, rb, dn, per_bad, last_rise;
      logic prev;
      logic [3:0] mw;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst.cs_n", cs_a, 1);
      chk("rst.sclk", sclk_a, 0);
      chk("rst.mosi", mosi_a, 0);
      chk("rst.busy", busy_a, 0);
      chk("rst.done", done_a, 0);
      chk("rst.rx", rx_a, 0);
      rst_n = 1'b1;

      // loopback 0xA5
      miso_mode = 0;
      start_xfer(8'hA5);
      wait_rec("a5", r);
      check_rec("a5", r, 8'hA5, 8'hA5, 1'b1);
      @(negedge clk);
      chk("a5.single_done", recs.size(), 0);

      // miso tied high, all-zero transmit
      miso_mode = 2;
      start_xfer(8'h00);
      wait_rec("ff", r);
      check_rec("ff", r, 8'h00, 8'hFF, 1'b1);
      chk("ff.mosi_ones", r.ones, 0);

      // second start mid-transfer and a start during DONE are both ignored
      miso_mode = 0;
      start_xfer(8'h3C);
      wait_rises(5);
      @(negedge clk);
      start_a = 1'b1;
      tx_a    = 8'hFF;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done_a) break;
         @(negedge clk);
      end
      chk("3c.done_seen", done_a, 1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_rec("3c", r);
      check_rec("3c", r, 8'h3C, 8'h3C, 1'b1);
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (!cs_a) n++;
      end
      chk("3c.no_restart", n, 0);
      chk("3c.one_done", recs.size(), 0);
      chk("3c.rx_hold", rx_a, 8'h3C);

      // reset during bit 3 aborts silently; start right after reset is taken
      start_xfer(8'h5A);
      wait_rises(4);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort.cs_n", cs_a, 1);
      chk("abort.sclk", sclk_a, 0);
      chk("abort.busy", busy_a, 0);
      chk("abort.done", done_a, 0);
      chk("abort.rx", rx_a, 0);
      rst_n   = 1'b1;
      start_a = 1'b1;
      tx_a    = 8'hC3;
      @(negedge clk);
      chk("abort.first_start", cs_a, 0);
      start_a = 1'b0;
      tx_a    = 8'h00;
      wait_rec("c3", r);
      check_rec("c3", r, 8'hC3, 8'hC3, 1'b1);

      // start held high: back-to-back transfers
      @(negedge clk);
      start_a = 1'b1;
      tx_a    = 8'h81;
      @(negedge clk);
      tx_a    = 8'h7E;
      wait_rec("b2b1", r);
      for (int i = 0; i < 10; i++) begin
         if (!cs_a) break;
         @(negedge clk);
      end
      start_a = 1'b0;
      wait_rec("b2b2", r2);
      check_rec("b2b1", r, 8'h81, 8'h81, 1'b1);
      check_rec("b2b2", r2, 8'h7E, 8'h7E, 1'b1);
      chk("b2b.gap", r2.gap, 2);
      repeat (6) @(negedge clk);
      chk("b2b.no_third", recs.size(), 0);
      chk("b2b.rx_hold", rx_a, 8'h7E);

      // randomized words, loopback or random miso
      for (int k = 0; k < 6; k++) begin
         d         = 8'($urandom);
         miso_mode = $urandom_range(0, 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_xfer(d);
         wait_rec("rnd", r);
         check_rec("rnd", r, d, d, miso_mode == 0);
         repeat ($urandom_range(1, 5)) @(negedge clk);
         chk("rnd.rx_hold", rx_a, r.rx);
      end
      chk("busy_window", busy_bad, 0);

      // 4-bit, divide-by-1 instance, loopback 0x9
      @(negedge clk);
      start_b = 1'b1;
      tx_b    = 4'h9;
      @(negedge clk);
      start_b = 1'b0;
      tx_b    = 4'h0;
      cs_lo = 0; rb = 0; dn = 0; per_bad = 0; last_rise = -1; prev = 1'b0; mw = '0;
      for (int i = 0; i < 40; i++) begin
         if (!cs_b) cs_lo++;
         if (sclk_b && !prev) begin
            if (last_rise >= 0 && (i - last_rise) != 2) per_bad++;
            last_rise = i;
            rb++;
            mw = {mw[2:0], mosi_b};
         end
         if (done_b) dn++;
         prev = sclk_b;
         @(negedge clk);
      end
      chk("b.cs_low", cs_lo, 9);
      chk("b.rises", rb, 4);
      chk("b.period", per_bad, 0);
      chk("b.mosi", mw, 4'h9);
      chk("b.done_cnt", dn, 1);
      chk("b.rx", rx_b, 4'h9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the transfer length in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter CLKDIV, default 4, giving the SCLK half-period in clk cycles (CLKDIV >= 1).
REQ-003 The block SHALL have one clock and one reset: synchronous, active-low.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  transfer request; sampled only in IDLE.
REQ-007 tx_data  input  WIDTH  word to transmit, MSB first; captured on the start-accept edge.
REQ-008 rx_data  output  WIDTH  last complete received word.
REQ-009 busy  output  1  high from the cycle after start-accept through the DONE cycle inclusive.
REQ-010 done  output  1  one-cycle pulse when rx_data is updated.
REQ-011 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 cs_n  output  1  active-low chip select.
REQ-013 mosi  output  1  serial data out.
REQ-014 miso  input  1  serial data in, synchronous to clk.

Function
REQ-015 FSM states SHALL be IDLE, LEAD, HIGH, LOW, TRAIL, DONE; each of LEAD/HIGH/LOW/TRAIL SHALL last exactly CLKDIV cycles, timed by a divider counter cleared on every state change.
REQ-016 IDLE: cs_n=1, sclk=0, mosi=0, busy=0; start=1 SHALL load tx_data into the shift register and go to LEAD.
REQ-017 LEAD: cs_n=0, sclk=0, mosi=shift-register MSB; at expiry go to HIGH.
REQ-018 On every edge entering HIGH, miso SHALL be shifted into the receive register LSB (left shift).
REQ-019 HIGH: sclk=1; at expiry, bit counter = WIDTH-1 goes to TRAIL, else the bit counter increments, the transmit register shifts left, and the state goes to LOW.
REQ-020 LOW: sclk=0, mosi = new MSB; at expiry go to HIGH.
REQ-021 TRAIL: cs_n=0, sclk=0; at expiry go to DONE.
REQ-022 DONE lasts one cycle: cs_n=1, done=1, rx_data = receive register; then go to IDLE.
REQ-023 A transfer SHALL give exactly WIDTH sclk rising edges, with cs_n low for (2*WIDTH+1)*CLKDIV cycles.
REQ-024 start while not IDLE (including DONE) SHALL be ignored; tx_data changes after accept SHALL not affect the transfer.
REQ-025 With start held high, cs_n SHALL be high for exactly 2 cycles (DONE, IDLE) between transfers.
REQ-026 The bit counter is clog2(WIDTH) bits and the divider counter clog2(CLKDIV)+1 bits; neither SHALL wrap.
REQ-027 rx_data SHALL hold its value between done pulses.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, and clear all counters and shift registers.
REQ-029 Reset mid-transfer SHALL abort without a done pulse; the first start is accepted on the first edge after rst_n returns high.

Structure
REQ-030 The state enumeration and the SPI mode constants SHALL reside in the shared package spi_pkg.
REQ-031 The shift register SHALL be the sub-module spi_shift_reg (WIDTH-parameterized, load/shift enables, serial in/out), instantiated twice (tx, rx).

Verification
REQ-032 WIDTH=8, CLKDIV=4, tx_data=0xA5, miso looped to mosi -> 8 sclk rises, cs_n low 68 cycles, done one cycle, rx_data=0xA5.
REQ-033 miso tied 1, tx_data=0x00 -> mosi constant 0, rx_data=0xFF.
REQ-034 start=1 tx_data=0x3C, then start=1 tx_data=0xFF at bit 4 -> second request ignored, mosi carries 0x3C, one done only.
REQ-035 rst_n=0 for one cycle during bit 3 -> next cycle cs_n=1, sclk=0, busy=0, rx_data=0x00, no done.
REQ-036 start held high, two transfers (0x81 then 0x7E) -> cs_n high exactly 2 cycles between them; rx_data after each matches loopback.
REQ-037 CLKDIV=1, WIDTH=4, tx_data=0x9 loopback -> sclk period 2 cycles, cs_n low 9 cycles, rx_data=0x9.
